axis_pixel_unpacker: RTL and testbench
======================================

// Module: axis_pixel_unpacker
// PURPOSE
//  Upstream feeder for the dnn input stream. Accepts packed 32-bit AXI-Stream beats from DMA
//  (4 x 8-bit pixels, lane 0 first) and emits one widened pixel per handshake on the dnn pixel
//  port (axis_in_data/axis_in_data_valid). Counts pixels per image and checks TLAST alignment
//  against FRAME_LEN; flags misframed images with a sticky error.
// PARAMETERS
//  IN_WIDTH   32   packed input beat width; multiple of LANE_WIDTH
//  LANE_WIDTH 8    raw pixel width; LANES = IN_WIDTH/LANE_WIDTH
//  OUT_WIDTH  16   output sample width (`dataWidth); must be >= LANE_WIDTH+PIX_SHIFT
//  PIX_SHIFT  0    left shift applied to zero-extended pixel (fixed-point alignment)
//  FRAME_LEN  784  pixels per image (28x28)
// PORTS
//  s_axi_aclk       in   1          clock
//  s_axi_aresetn    in   1          async active-low reset
//  s_axis_tdata     in   IN_WIDTH   packed pixels, lane k = bits [k*LANE_WIDTH +: LANE_WIDTH]
//  s_axis_tkeep     in   LANES      lane-valid mask; cleared lanes skipped
//  s_axis_tlast     in   1          last beat of image
//  s_axis_tvalid    in   1          beat valid
//  s_axis_tready    out  1          beat accepted when tvalid&tready
//  m_pix_data       out  OUT_WIDTH  pixel = zext(lane) << PIX_SHIFT
//  m_pix_valid      out  1          pixel valid
//  m_pix_ready      in   1          downstream ready (tie 1 for dnn)
//  frame_done       out  1          1-cycle pulse when pixel FRAME_LEN-1 transfers
//  frame_err        out  1          sticky misframe flag
//  err_clr          in   1          clears frame_err (and error count)
// BEHAVIOUR
//  - Reset: s_axis_tready=1, m_pix_valid=0, m_pix_data=0, frame_done=0, frame_err=0, hold empty,
//    pix_cnt=0. Reset mid-image discards held beat and partial count; no frame_done.
//  - Hold register: one beat + remaining keep mask + latched tlast. States EMPTY / HOLD.
//  - EMPTY: tready=1; beat accepted -> HOLD with mask=tkeep. Beat with tkeep=0 accepted and dropped
//    (but its tlast is still checked). m_pix_valid=0 in EMPTY.
//  - HOLD: m_pix_valid=1, m_pix_data = lowest set lane of mask. On m_pix_valid&m_pix_ready clear
//    that lane bit. tready=1 only when exactly one lane remains and m_pix_ready=1 (accept next
//    beat same cycle as last pixel transfer: zero-bubble, 1 pixel/clk sustained).
//  - Latency: first pixel of a beat valid 1 cycle after beat acceptance.
//  - pix_cnt increments per output transfer; at FRAME_LEN-1 transfer: frame_done pulse, pix_cnt->0.
//  - TLAST check at the final pixel transfer of a beat: err if tlast=1 and pixel is not
//    FRAME_LEN-1, or tlast=0 and pixel is FRAME_LEN-1. On tlast-err, pix_cnt resyncs to 0 (frame
//    restarts); frame_done not pulsed for short frames.
//  - frame_err set has priority over err_clr in same cycle.
//  - m_pix_data/m_pix_valid stable while m_pix_valid&!m_pix_ready (AXIS rule).
// CONFIGURATION
//  PIXUNPACK_ERRCNT_EN defined: adds output err_count [15:0], increments on each frame_err event,
//    saturates at 16'hFFFF, cleared by err_clr (set wins over clear, count+1 from 0 -> 1).
//  Not defined: no err_count port; only sticky frame_err.
// TESTING
//  - 196 full-keep beats 0x04030201.. with tlast on beat 196, ready=1 -> 784 pixels, 1/clk, lane
//    order 01,02,03,04; single frame_done on pixel 783; frame_err=0.
//  - Random m_pix_ready backpressure (50%) on same image -> identical pixel sequence, data held
//    stable while stalled, no loss/duplication.
//  - tkeep=4'b0101 beat 0x44332211 -> pixels 0x11,0x33 only; tkeep=0 beat -> no pixels.
//  - tlast on beat 100 (400 pixels) -> frame_err=1, no frame_done, next 784-pixel image counts
//    from 0 and pulses frame_done; err_clr -> frame_err=0.
//  - PIX_SHIFT=4, pixel 0xFF -> m_pix_data=16'h0FF0.
//  - Assert s_axi_aresetn low mid-image -> outputs at reset values next edge; new image after
//    release frames correctly.

Source files
------------

// File: rtl/axis_pixel_unpacker.sv
// rtl/axis_pixel_unpacker.sv - packed AXI-Stream beats to one widened pixel per handshake
//
// Purpose:
//   Takes IN_WIDTH-bit beats holding LANES pixels of LANE_WIDTH bits each (lane 0 first).
//   Emits the kept lanes one at a time on m_pix_*, zero-extended to OUT_WIDTH and shifted
//   left by PIX_SHIFT. Pixels are counted per image. TLAST is checked against FRAME_LEN
//   at the final pixel of each beat, and a misframed image sets a sticky error flag.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn         clock, asynchronous active-low reset
//   s_axis_tdata/tkeep/tlast/tvalid   packed input beat; s_axis_tready accepts it
//   m_pix_data/m_pix_valid            widened output pixel; m_pix_ready from downstream
//   frame_done                        1-cycle pulse while pixel FRAME_LEN-1 transfers
//   frame_err                         sticky misframe flag; err_clr clears it
//   err_count                         (PIXUNPACK_ERRCNT_EN only) saturating error count
//
// Optional feature macro: PIXUNPACK_ERRCNT_EN adds the err_count output.

module axis_pixel_unpacker #(
    parameter int IN_WIDTH   = 32,
    parameter int LANE_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int PIX_SHIFT  = 0,
    parameter int FRAME_LEN  = 784
) (
    input  logic                             s_axi_aclk,
    input  logic                             s_axi_aresetn,
    input  logic [IN_WIDTH-1:0]              s_axis_tdata,
    input  logic [IN_WIDTH/LANE_WIDTH-1:0]   s_axis_tkeep,
    input  logic                             s_axis_tlast,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic [OUT_WIDTH-1:0]             m_pix_data,
    output logic                             m_pix_valid,
    input  logic                             m_pix_ready,
    output logic                             frame_done,
    output logic                             frame_err,
    input  logic                             err_clr
`ifdef PIXUNPACK_ERRCNT_EN
    ,
    output logic [15:0]                      err_count
`endif
);

    localparam int LANES = IN_WIDTH / LANE_WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [IN_WIDTH-1:0]    hold_data;
    logic [LANES-1:0]       hold_mask;
    logic                   hold_last;
    logic [CNT_W-1:0]       pix_cnt;

    logic [IDX_W-1:0]       lane_sel;
    logic [LANE_WIDTH-1:0]  lane_pix;
    logic [LANES-1:0]       mask_rest;
    logic                   one_left;
    logic                   xfer;
    logic                   beat_done;
    logic                   accept;
    logic                   load_beat;
    logic                   is_end;
    logic                   tlast_err;
    logic                   empty_err;
    logic                   err_event;
    logic [CNT_W-1:0]       cnt_after;
    logic [CNT_W-1:0]       pix_cnt_nxt;

    // Lowest set lane of the remaining mask is the next pixel to send.
    always_comb begin
        lane_sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hold_mask[i]) begin
                lane_sel = IDX_W'(i);
            end
        end
    end

    assign lane_pix  = hold_data[lane_sel*LANE_WIDTH +: LANE_WIDTH];
    // Clearing the lowest set bit leaves the lanes still to be sent.
    assign mask_rest = hold_mask & (hold_mask - LANES'(1));
    assign one_left  = (hold_mask != '0) && (mask_rest == '0);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_pix_valid   = 1'b0;
        xfer          = 1'b0;
        beat_done     = 1'b0;
        case (state)
            ST_EMPTY: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && (s_axis_tkeep != '0)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                m_pix_valid = 1'b1;
                xfer        = m_pix_ready;
                beat_done   = m_pix_ready && one_left;
                // Taking the next beat while the last lane leaves keeps 1 pixel/clk.
                s_axis_tready = beat_done;
                if (beat_done) begin
                    state_nxt = (s_axis_tvalid && (s_axis_tkeep != '0)) ? ST_HOLD : ST_EMPTY;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign load_beat = accept && (s_axis_tkeep != '0);
    assign is_end    = (pix_cnt == CNT_LAST);
    // A beat's final pixel must coincide with the image end exactly when tlast is set.
    assign tlast_err = beat_done && (hold_last != is_end);

    always_comb begin
        cnt_after = pix_cnt;
        if (xfer) begin
            cnt_after = (is_end || tlast_err) ? '0 : pix_cnt + CNT_W'(1);
        end
    end

    // An all-lanes-cleared beat carries no pixels, but its tlast still has to land on an
    // image boundary, judged against the count after any pixel leaving this cycle.
    assign empty_err   = accept && (s_axis_tkeep == '0) && s_axis_tlast && (cnt_after != '0);
    assign pix_cnt_nxt = empty_err ? '0 : cnt_after;
    assign err_event   = tlast_err || empty_err;

    assign frame_done  = xfer && is_end;
    assign m_pix_data  = m_pix_valid ? (OUT_WIDTH'(lane_pix) << PIX_SHIFT) : '0;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            hold_data <= '0;
            hold_mask <= '0;
            hold_last <= 1'b0;
            pix_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (load_beat) begin
                hold_data <= s_axis_tdata;
                hold_mask <= s_axis_tkeep;
                hold_last <= s_axis_tlast;
            end else if (xfer) begin
                hold_mask <= mask_rest;
            end
            pix_cnt <= pix_cnt_nxt;
            if (err_event) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef PIXUNPACK_ERRCNT_EN
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            err_count <= '0;
        end else if (err_event) begin
            // A new error in the clear cycle restarts the count at one.
            if (err_clr) begin
                err_count <= 16'd1;
            end else if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end else if (err_clr) begin
            err_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// tb/tb_axis_pixel_unpacker.sv - self-checking bench for axis_pixel_unpacker
module tb_axis_pixel_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [15:0] m_pix_data;
    logic        m_pix_valid;
    logic        m_pix_ready = 1'b1;
    logic        frame_done;
    logic        frame_err;
    logic        err_clr = 1'b0;
`ifdef PIXUNPACK_ERRCNT_EN
    logic [15:0] err_count;
    logic [15:0] err_count2;
`endif

    logic [31:0] tdata2 = '0;
    logic [3:0]  tkeep2 = '0;
    logic        tlast2 = 1'b0;
    logic        tvalid2 = 1'b0;
    logic        tready2;
    logic [15:0] pix_data2;
    logic        pix_valid2;
    logic        pix_ready2 = 1'b1;
    logic        frame_done2;
    logic        frame_err2;

    axis_pixel_unpacker u_dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_pix_data    (m_pix_data),
        .m_pix_valid   (m_pix_valid),
        .m_pix_ready   (m_pix_ready),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .err_clr       (err_clr)
`ifdef PIXUNPACK_ERRCNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    axis_pixel_unpacker #(.PIX_SHIFT(4)) u_dut_shift (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axis_tdata  (tdata2),
        .s_axis_tkeep  (tkeep2),
        .s_axis_tlast  (tlast2),
        .s_axis_tvalid (tvalid2),
        .s_axis_tready (tready2),
        .m_pix_data    (pix_data2),
        .m_pix_valid   (pix_valid2),
        .m_pix_ready   (pix_ready2),
        .frame_done    (frame_done2),
        .frame_err     (frame_err2),
        .err_clr       (err_clr)
`ifdef PIXUNPACK_ERRCNT_EN
        ,
        .err_count     (err_count2)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [15:0] got[$];
    int fd_cnt = 0;
    int fd_idx = -1;
    int first_cyc = 0;
    int last_cyc = 0;
    bit rand_rdy = 1'b0;
    bit stall_pend = 1'b0;
    logic [15:0] stall_data = '0;

    typedef struct {
        logic [31:0]      data;
        logic [3:0]       keep;
        int               n;
        logic [3:0][7:0]  pix;
    } vec_t;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (rand_rdy) m_pix_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: records transfers, frame_done position, and stall stability.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (stall_pend) begin
                n_chk++;
                if (!(m_pix_valid && m_pix_data == stall_data)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b data=%h want valid=1 data=%h",
                             m_pix_valid, m_pix_data, stall_data);
                end
            end
            stall_pend = m_pix_valid && !m_pix_ready;
            stall_data = m_pix_data;
            if (m_pix_valid && m_pix_ready) begin
                if (got.size() == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (frame_done) fd_idx = got.size();
                got.push_back(m_pix_data);
            end
            if (frame_done) fd_cnt++;
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #3;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        logic acc;
        t = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            #1;
            acc = s_axis_tready;
            @(negedge clk);
            if (acc) break;
            t++;
            if (t > 200) begin
                chk("beat_accept_timeout", 32'(t), 32'd0);
                break;
            end
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_image(input int nbeats, input bit do_idle);
        logic [31:0] d;
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(4 * b + k + 1);
            send_beat(d, 4'hF, b == nbeats - 1);
        end
        if (do_idle) idle();
    endtask

    task automatic wait_pix(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 4000) begin
            cycle();
            t++;
        end
        repeat (4) cycle();
        chk("pixel_count", 32'(got.size()), 32'(n));
    endtask

    task automatic chk_seq(input string name);
        int mism;
        int first_bad;
        mism = 0;
        first_bad = -1;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== 16'((i + 1) & 8'hFF)) begin
                if (first_bad < 0) first_bad = i;
                mism++;
            end
        end
        n_chk++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s: %0d wrong pixels (first at %0d), want 0", name, mism, first_bad);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        fd_cnt = 0;
        fd_idx = -1;
    endtask

    initial begin
        vecs[0] = '{32'h04030201, 4'b1111, 4, {8'h04, 8'h03, 8'h02, 8'h01}};
        vecs[1] = '{32'h44332211, 4'b0101, 2, {8'h00, 8'h00, 8'h33, 8'h11}};
        vecs[2] = '{32'hDEADBEEF, 4'b0000, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{32'hA1B2C3D4, 4'b1000, 1, {8'h00, 8'h00, 8'h00, 8'hA1}};
        vecs[4] = '{32'h55667788, 4'b0110, 2, {8'h00, 8'h00, 8'h66, 8'h77}};
        vecs[5] = '{32'h0000FF00, 4'b0010, 1, {8'h00, 8'h00, 8'h00, 8'hFF}};

        rst_n = 1'b0;
        repeat (3) cycle();
        chk("rst_tready", 32'(s_axis_tready), 32'd1);
        chk("rst_valid", 32'(m_pix_valid), 32'd0);
        chk("rst_data", 32'(m_pix_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Full image, no backpressure: 784 pixels at one per clock.
        clear_mon();
        send_image(196, 1'b1);
        wait_pix(784);
        chk_seq("full_seq");
        chk("full_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("full_fd_idx", 32'(fd_idx), 32'd783);
        chk("full_span", 32'(last_cyc - first_cyc), 32'd783);
        chk("full_err", 32'(frame_err), 32'd0);

        // Same image under random backpressure.
        clear_mon();
        rand_rdy = 1'b1;
        send_image(196, 1'b1);
        wait_pix(784);
        rand_rdy = 1'b0;
        m_pix_ready = 1'b1;
        chk_seq("bp_seq");
        chk("bp_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("bp_fd_idx", 32'(fd_idx), 32'd783);
        chk("bp_err", 32'(frame_err), 32'd0);

        // Single-beat keep patterns.
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_beat(vecs[v].data, vecs[v].keep, 1'b0);
            idle();
            repeat (6) cycle();
            chk($sformatf("keep%0d_count", v), 32'(got.size()), 32'(vecs[v].n));
            for (int k = 0; k < vecs[v].n && k < got.size(); k++) begin
                chk($sformatf("keep%0d_pix%0d", v, k), 32'(got[k]), 32'(vecs[v].pix[k]));
            end
        end
        chk("keep_err", 32'(frame_err), 32'd0);

        // Short frame: tlast on beat 100.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        clear_mon();
        send_image(100, 1'b1);
        wait_pix(400);
        chk("short_err", 32'(frame_err), 32'd1);
        chk("short_fd_cnt", 32'(fd_cnt), 32'd0);
`ifdef PIXUNPACK_ERRCNT_EN
        chk("short_err_count", 32'(err_count), 32'd1);
`endif
        clear_mon();
        send_image(196, 1'b1);
        wait_pix(784);
        chk_seq("resync_seq");
        chk("resync_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("resync_fd_idx", 32'(fd_idx), 32'd783);
        chk("resync_err_sticky", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        cycle();
        chk("err_clr", 32'(frame_err), 32'd0);

        // Reset in the middle of an image.
        clear_mon();
        send_image(50, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tready", 32'(s_axis_tready), 32'd1);
        chk("midrst_valid", 32'(m_pix_valid), 32'd0);
        chk("midrst_data", 32'(m_pix_data), 32'd0);
        chk("midrst_fd", 32'(frame_done), 32'd0);
        chk("midrst_fd_cnt", 32'(fd_cnt), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        clear_mon();
        send_image(196, 1'b1);
        wait_pix(784);
        chk_seq("postrst_seq");
        chk("postrst_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("postrst_fd_idx", 32'(fd_idx), 32'd783);
        chk("postrst_err", 32'(frame_err), 32'd0);

        // PIX_SHIFT=4 instance: 0xFF -> 0x0FF0, valid one cycle after acceptance.
        @(negedge clk);
        tdata2  = 32'h000000FF;
        tkeep2  = 4'b0001;
        tvalid2 = 1'b1;
        #1;
        chk("shift_tready", 32'(tready2), 32'd1);
        chk("shift_pre_valid", 32'(pix_valid2), 32'd0);
        @(negedge clk);
        tvalid2 = 1'b0;
        #1;
        chk("shift_valid", 32'(pix_valid2), 32'd1);
        chk("shift_data", 32'(pix_data2), 32'h0FF0);
        cycle();
        chk("shift_drained", 32'(pix_valid2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
